// File: rtl/debug_reg_dumper_pkg.sv
// Shared constants and FSM encoding for the debug register dumper.
package debug_reg_dumper_pkg;

  localparam int PROC_BITS      = 32;
  localparam int REG_ADDRS_BITS = 5;
  localparam int REG_COUNT      = 1 << REG_ADDRS_BITS;
  localparam int SNAP_W         = PROC_BITS * REG_COUNT;
  localparam int BIT_IDX_W      = $clog2(SNAP_W);

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/debug_reg_dumper.sv
// Snapshots the flattened register file and streams it out as a framed byte
// dump: one header byte, then every register MSB byte first, reg 0 upward.
module debug_reg_dumper
  import debug_reg_dumper_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [SNAP_W-1:0] i_debug_regs,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_done
);

  state_e                    state_q, state_d;
  logic [REG_ADDRS_BITS-1:0] reg_idx_q, reg_idx_d;
  logic [1:0]                byte_idx_q, byte_idx_d;
  logic [SNAP_W-1:0]         snap_q;
  logic [BIT_IDX_W-1:0]      bit_hi;
  logic                      xfer;

  assign xfer = o_tx_valid & i_tx_ready;

  // Top bit of the current byte: 32*reg_idx + 31 - 8*byte_idx (never underflows).
  assign bit_hi = {reg_idx_q, 5'd31} - {{(BIT_IDX_W-5){1'b0}}, byte_idx_q, 3'b000};

  // Snapshot is taken only when a dump is accepted; reset leaves it alone.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == ST_IDLE && i_start)
      snap_q <= i_debug_regs;
  end

  // State and byte counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Next state, counter advance and outputs, all decoded from the current state.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_d    = ST_HEADER;
          reg_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      ST_HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HEADER_BYTE;
        if (xfer) begin
          state_d    = ST_DATA;
          reg_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      ST_DATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = snap_q[bit_hi -: 8];
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            reg_idx_d = reg_idx_q + 1'b1;
            if (reg_idx_q == REG_ADDRS_BITS'(REG_COUNT - 1))
              state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized bench for debug_reg_dumper against a queue-based frame model.
module tb_debug_reg_dumper;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [1023:0] i_debug_regs;
  logic          i_tx_ready;
  logic          o_tx_valid;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic          o_done;

  logic [31:0] regs [32];
  byte unsigned exp_q[$];
  byte unsigned got[$];
  int total = 0;
  int bad   = 0;

  // Results of the last run_frame call.
  int done_cnt, stall_bad, first_valid_cyc, done_cyc, valid_cycles;
  bit timed_out;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 32; i++) i_debug_regs[32*i +: 32] = regs[i];

  debug_reg_dumper dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_debug_regs(i_debug_regs),
    .i_tx_ready(i_tx_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Expected frame from the register values at the moment of start.
  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(byte'((regs[r] >> (8*b)) & 32'hFF));
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    after_edge();
    i_start = 1'b0;
  endtask

  // Drives ready (mode 0: always, 1: 1,0,0 pattern, 2: random) and collects
  // accepted bytes until o_done, stop_at bytes, or the cycle budget.
  task automatic run_frame(input int mode, input int chg_cyc, input int start_at,
                           input int stop_at);
    bit pv, pr, fired;
    byte unsigned pd;
    got.delete();
    done_cnt = 0; stall_bad = 0; first_valid_cyc = -1; done_cyc = -1;
    valid_cycles = 0; timed_out = 1'b1; pv = 0; pr = 0; pd = 0; fired = 0;
    for (int c = 0; c < 2000; c++) begin
      case (mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (c % 3 == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == chg_cyc) regs[3] = 32'h0;
      i_start = (!fired && got.size() == start_at);
      if (i_start) fired = 1;
      @(negedge clk);
      if (pv && !pr && (o_tx_valid !== 1'b1 || o_tx_data !== pd)) stall_bad++;
      pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
      if (o_tx_valid === 1'b1) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = c;
        if (i_tx_ready) got.push_back(o_tx_data);
      end
      if (o_done === 1'b1) begin
        done_cnt++; done_cyc = c; timed_out = 1'b0;
        break;
      end
      if (stop_at >= 0 && got.size() >= stop_at) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_tx_ready = 1'b1;
    after_edge(); after_edge();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got v=%b b=%b d=%b data=%h want 0 0 0 00",
                 c, o_tx_valid, o_busy, o_done, o_tx_data);
      end
    end
    after_edge();
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 * i + i;
    build_expected();
    pulse_start();
    run_frame(0, -1, -1, -1);
    total++;
    if (got.size() != 129 || timed_out) begin
      bad++; $display("FAIL full_len got=%0d want=129 timeout=%0b", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 129; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL full_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    total++;
    if (valid_cycles != 129 || first_valid_cyc != 0 || done_cyc != 129) begin
      bad++;
      $display("FAIL full_timing got valid=%0d first=%0d done=%0d want 129 0 129",
               valid_cycles, first_valid_cyc, done_cyc);
    end
    total++;
    if (o_busy !== 1'b1 || o_tx_valid !== 1'b0) begin
      bad++; $display("FAIL done_cycle got busy=%b valid=%b want 1 0", o_busy, o_tx_valid);
    end
    after_edge(); @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL after_done got busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_backpressure(input int mode);
    after_edge();
    if (mode == 2) randomize_regs();
    else for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 * i + i;
    build_expected();
    pulse_start();
    run_frame(mode, -1, -1, -1);
    total++;
    if (got.size() != 129 || done_cnt != 1) begin
      bad++; $display("FAIL bp%0d_len got=%0d done=%0d want 129 1", mode, got.size(), done_cnt);
    end
    for (int i = 0; i < got.size() && i < 129; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp%0d_byte[%0d] got=%h want=%h", mode, i, got[i], exp_q[i]);
      end
    end
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL bp%0d_stable got=%0d unstable stalls want=0", mode, stall_bad);
    end
  endtask

  task automatic test_snapshot();
    after_edge();
    randomize_regs();
    regs[3] = 32'hDEAD_BEEF;
    build_expected();
    pulse_start();
    run_frame(2, 2, -1, -1);
    total++;
    if (got.size() != 129) begin
      bad++; $display("FAIL snap_len got=%0d want=129", got.size());
    end else begin
      total++;
      if ({got[13], got[14], got[15], got[16]} !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL snap_reg3 got=%h%h%h%h want=deadbeef", got[13], got[14], got[15], got[16]);
      end
      for (int i = 0; i < 129; i++) begin
        total++;
        if (got[i] !== exp_q[i]) begin
          bad++; $display("FAIL snap_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    after_edge();
    randomize_regs();
    build_expected();
    pulse_start();
    run_frame(0, -1, 50, -1);
    total++;
    if (got.size() != 129 || done_cnt != 1) begin
      bad++; $display("FAIL busy_start got len=%0d done=%0d want 129 1", got.size(), done_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      after_edge(); @(negedge clk);
      total++;
      if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
        bad++; $display("FAIL busy_no_queue cyc=%0d got busy=%b valid=%b want 0 0", c, o_busy, o_tx_valid);
      end
    end
  endtask

  task automatic test_start_held();
    after_edge();
    randomize_regs();
    build_expected();
    i_start = 1'b1;
    after_edge();
    run_frame(0, -1, -1, -1);
    i_start = 1'b1;
    after_edge(); @(negedge clk);
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL held_idle got busy=%b want 0", o_busy);
    end
    after_edge(); i_start = 1'b0; @(negedge clk);
    total++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5) begin
      bad++; $display("FAIL held_restart got v=%b d=%h want 1 a5", o_tx_valid, o_tx_data);
    end
    after_edge();
    run_frame(0, -1, -1, -1);
    total++;
    if (got.size() != 128 || done_cnt != 1) begin
      bad++; $display("FAIL held_drain got len=%0d done=%0d want 128 1", got.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    after_edge();
    randomize_regs();
    build_expected();
    pulse_start();
    run_frame(0, -1, -1, 70);
    after_edge();
    rst_n = 1'b0;
    i_tx_ready = 1'b1;
    after_edge();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset cyc=%0d got v=%b b=%b d=%b want 0 0 0", c, o_tx_valid, o_busy, o_done);
      end
      after_edge();
    end
    randomize_regs();
    build_expected();
    pulse_start();
    run_frame(2, -1, -1, -1);
    total++;
    if (got.size() != 129 || done_cnt != 1) begin
      bad++; $display("FAIL mid_restart_len got=%0d done=%0d want 129 1", got.size(), done_cnt);
    end
    for (int i = 0; i < got.size() && i < 129; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL mid_restart_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    test_reset();
    test_full_dump();
    test_backpressure(1);
    test_backpressure(2);
    test_snapshot();
    test_start_busy();
    test_start_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
